// File: rtl/interval_timer.sv
// interval_timer: memory-mapped programmable down-counting timer that
// drives one CP0 hardware interrupt line.
//
// Ports:
//   clk    system clock, rising edge active
//   reset  asynchronous, active-high reset
//   Addr   word offset in the timer window (0 CTRL, 1 PRESET, 2 COUNT, 3 reserved)
//   WE     register write enable from the bridge
//   Din    write data
//   Dout   read data, combinational from Addr
//   IRQ    interrupt request (IM & irq_flag), registered sources only
//
// Optional build macro TIMER_PRESCALE_EN: adds an 8-bit prescaler so COUNT
// decrements once every PRESCALE_DIV cycles spent in CNT (legal 1..256).
module interval_timer #(
   parameter int unsigned PRESCALE_DIV = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  Addr,
   input  logic        WE,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   output logic        IRQ
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CTRL_W = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_CNT  = 2'd2,
      S_INT  = 2'd3
   } state_t;

   // Reject out-of-range divider at elaboration.
   if (PRESCALE_DIV < 1 || PRESCALE_DIV > 256) begin : g_bad_div
      $error("interval_timer: PRESCALE_DIV must be in 1..256");
   end

   state_t              state;
   logic [CTRL_W-1:0]   ctrl;
   logic [DATA_W-1:0]   preset;
   logic [DATA_W-1:0]   count;
   logic                irq_flag;

   logic                en;
   logic [1:0]          mode;
   logic                im;
   logic                ctrl_we_c;
   logic                preset_we_c;
   logic                tick_c;

   assign en          = ctrl[0];
   assign mode        = ctrl[2:1];
   assign im          = ctrl[3];
   assign ctrl_we_c   = WE && (Addr == 2'd0);
   assign preset_we_c = WE && (Addr == 2'd1);

`ifdef TIMER_PRESCALE_EN
   localparam logic [7:0] PRESC_LAST = 8'(PRESCALE_DIV - 1);

   logic [7:0] presc;

   // Counts cycles spent counting; a tick fires on the last cycle of each divide window.
   assign tick_c = (presc == PRESC_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc <= 8'd0;
      end else if (state == S_LOAD) begin
         presc <= 8'd0;
      end else if (state == S_CNT && en) begin
         presc <= tick_c ? 8'd0 : presc + 8'd1;
      end
   end
`else
   assign tick_c = 1'b1;
`endif

   // Timer FSM plus register file; software writes are applied last so they
   // override the FSM's EN clear and irq_flag set in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         ctrl     <= '0;
         preset   <= '0;
         count    <= '0;
         irq_flag <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (en) state <= S_LOAD;
            end
            S_LOAD: begin
               count <= preset;
               state <= S_CNT;
            end
            S_CNT: begin
               if (!en) begin
                  state <= S_IDLE;
               end else if (tick_c) begin
                  // COUNT of 0 or 1 both terminate, so PRESET=0 acts as PRESET=1.
                  if (count > DATA_W'(1)) begin
                     count <= count - DATA_W'(1);
                  end else begin
                     count    <= '0;
                     irq_flag <= 1'b1;
                     state    <= S_INT;
                  end
               end
            end
            S_INT: begin
               if (mode == 2'd1) begin
                  irq_flag <= 1'b0;
                  state    <= S_LOAD;
               end else begin
                  ctrl[0] <= 1'b0;
                  state   <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase

         if (ctrl_we_c)   ctrl   <= Din[CTRL_W-1:0];
         if (preset_we_c) preset <= Din;
         if (ctrl_we_c || preset_we_c) irq_flag <= 1'b0;
      end
   end

   // Read mux; all sources are registers, so Dout is 0 while reset is held.
   always_comb begin
      Dout = '0;
      case (Addr)
         2'd0:    Dout = {{(DATA_W-CTRL_W){1'b0}}, ctrl};
         2'd1:    Dout = preset;
         2'd2:    Dout = count;
         default: Dout = '0;
      endcase
   end

   assign IRQ = im & irq_flag;

endmodule

// File: tb/tb_interval_timer.sv
// tb_interval_timer: self-checking bench for interval_timer. Directed
// scenarios plus randomized programs checked against a cycle-timeline model
// derived from the load/count/interrupt timing rules.
module tb_interval_timer;

   logic        clk;
   logic        reset;
   logic [1:0]  Addr;
   logic        WE;
   logic [31:0] Din;
   logic [31:0] Dout;
   logic        IRQ;

   int n_checks;
   int n_fail;

   interval_timer dut (
      .clk   (clk),
      .reset (reset),
      .Addr  (Addr),
      .WE    (WE),
      .Din   (Din),
      .Dout  (Dout),
      .IRQ   (IRQ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Write lands on the next rising edge; returns 1 time unit after it.
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      Addr = a;
      Din  = d;
      WE   = 1'b1;
      @(posedge clk);
      #1;
      WE = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      // Reset held from time zero.
      #2;
      n_checks++;
      if (IRQ !== 1'b0) begin
         n_fail++;
         $display("FAIL init_irq: got %b want 0", IRQ);
      end
      for (int a = 0; a < 4; a++) begin
         Addr = 2'(a);
         #1;
         n_checks++;
         if (Dout !== 32'd0) begin
            n_fail++;
            $display("FAIL init_dout addr=%0d: got %h want 0", a, Dout);
         end
      end
      @(negedge clk);
      reset = 1'b0;

      // Get IRQ high, then pulse reset between edges.
      wr(2'd1, 32'd1);
      wr(2'd0, 32'h9);
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (IRQ !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset_irq: got %b want 1", IRQ);
      end
      #2;
      reset = 1'b1;
      #1;
      n_checks++;
      if (IRQ !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset_irq: got %b want 0", IRQ);
      end
      for (int a = 0; a < 4; a++) begin
         Addr = 2'(a);
         #1;
         n_checks++;
         if (Dout !== 32'd0) begin
            n_fail++;
            $display("FAIL async_reset_dout addr=%0d: got %h want 0", a, Dout);
         end
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_oneshot();
      do_reset();
      wr(2'd1, 32'd5);
      wr(2'd0, 32'h9);                      // e0
      for (int t = 1; t <= 10; t++) begin
         @(posedge clk);
         #1;
         Addr = 2'd2;
         #1;
         if (t == 2) begin
            n_checks++;
            if (Dout !== 32'd5) begin
               n_fail++;
               $display("FAIL oneshot_count_e2: got %0d want 5", Dout);
            end
         end
         n_checks++;
         if (IRQ !== (t >= 7)) begin
            n_fail++;
            $display("FAIL oneshot_irq e%0d: got %b want %b", t, IRQ, (t >= 7));
         end
         if (t >= 8) begin
            Addr = 2'd0;
            #1;
            n_checks++;
            if (Dout !== 32'h8) begin
               n_fail++;
               $display("FAIL oneshot_ctrl e%0d: got %h want 8", t, Dout);
            end
         end
      end
      wr(2'd0, 32'h0);
      n_checks++;
      if (IRQ !== 1'b0) begin
         n_fail++;
         $display("FAIL oneshot_irq_clear: got %b want 0", IRQ);
      end
   endtask

   task automatic test_autoreload();
      int seq [5] = '{0, 3, 2, 1, 0};
      do_reset();
      wr(2'd1, 32'd3);
      wr(2'd0, 32'hB);                      // e0
      for (int t = 1; t <= 16; t++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (IRQ !== (t == 5 || t == 10 || t == 15)) begin
            n_fail++;
            $display("FAIL auto_irq e%0d: got %b", t, IRQ);
         end
         Addr = 2'd2;
         #1;
         n_checks++;
         if (Dout !== 32'(seq[(t - 1) % 5])) begin
            n_fail++;
            $display("FAIL auto_count e%0d: got %0d want %0d", t, Dout, seq[(t - 1) % 5]);
         end
         Addr = 2'd0;
         #1;
         n_checks++;
         if (Dout !== 32'hB) begin
            n_fail++;
            $display("FAIL auto_ctrl e%0d: got %h want b", t, Dout);
         end
      end
   endtask

   task automatic test_masked();
      do_reset();
      wr(2'd1, 32'd4);
      wr(2'd0, 32'h1);                      // e0
      for (int t = 1; t <= 9; t++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (IRQ !== 1'b0) begin
            n_fail++;
            $display("FAIL masked_irq e%0d: got %b want 0", t, IRQ);
         end
      end
      Addr = 2'd2;
      #1;
      n_checks++;
      if (Dout !== 32'd0) begin
         n_fail++;
         $display("FAIL masked_count: got %0d want 0", Dout);
      end
      Addr = 2'd0;
      #1;
      n_checks++;
      if (Dout !== 32'd0) begin
         n_fail++;
         $display("FAIL masked_ctrl: got %h want 0", Dout);
      end
   endtask

   task automatic test_stop_restart();
      do_reset();
      wr(2'd1, 32'd10);
      wr(2'd0, 32'h9);                      // e0
      repeat (4) @(posedge clk);
      wr(2'd0, 32'h8);                      // e5
      for (int t = 5; t <= 8; t++) begin
         if (t > 5) begin
            @(posedge clk);
            #1;
         end
         Addr = 2'd2;
         #1;
         n_checks++;
         if (Dout !== 32'd7 || IRQ !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_frozen e%0d: count %0d irq %b want 7/0", t, Dout, IRQ);
         end
      end
      wr(2'd1, 32'd2);
      wr(2'd0, 32'h9);                      // w
      for (int t = 1; t <= 4; t++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (IRQ !== (t == 4)) begin
            n_fail++;
            $display("FAIL restart_irq w+%0d: got %b want %b", t, IRQ, (t == 4));
         end
      end
   endtask

   task automatic test_collisions();
      // CTRL write in the INT cycle keeps EN and clears the flag.
      do_reset();
      wr(2'd1, 32'd2);
      wr(2'd0, 32'h9);                      // e0
      repeat (4) @(posedge clk);
      #1;
      n_checks++;
      if (IRQ !== 1'b1) begin
         n_fail++;
         $display("FAIL coll_int_irq e4: got %b want 1", IRQ);
      end
      wr(2'd0, 32'h9);                      // e5
      Addr = 2'd0;
      #1;
      n_checks++;
      if (Dout !== 32'h9 || IRQ !== 1'b0) begin
         n_fail++;
         $display("FAIL coll_ctrl_wins: ctrl %h irq %b want 9/0", Dout, IRQ);
      end
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (IRQ !== 1'b0) begin
         n_fail++;
         $display("FAIL coll_rerun_early e8: got %b want 0", IRQ);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (IRQ !== 1'b1) begin
         n_fail++;
         $display("FAIL coll_rerun_irq e9: got %b want 1", IRQ);
      end

      // PRESET write in the cycle the flag would set keeps the flag clear.
      do_reset();
      wr(2'd1, 32'd2);
      wr(2'd0, 32'h9);                      // e0
      repeat (3) @(posedge clk);
      wr(2'd1, 32'd2);                      // e4
      Addr = 2'd2;
      #1;
      n_checks++;
      if (IRQ !== 1'b0 || Dout !== 32'd0) begin
         n_fail++;
         $display("FAIL coll_preset_wins e4: irq %b count %0d want 0/0", IRQ, Dout);
      end
      @(posedge clk);
      #1;
      Addr = 2'd0;
      #1;
      n_checks++;
      if (IRQ !== 1'b0 || Dout !== 32'h8) begin
         n_fail++;
         $display("FAIL coll_preset_after e5: irq %b ctrl %h want 0/8", IRQ, Dout);
      end

      // PRESET write mid-count applies only at the next reload.
      do_reset();
      wr(2'd1, 32'd6);
      wr(2'd0, 32'hB);                      // e0
      repeat (2) @(posedge clk);
      wr(2'd1, 32'd2);                      // e3
      Addr = 2'd2;
      #1;
      n_checks++;
      if (Dout !== 32'd5) begin
         n_fail++;
         $display("FAIL coll_preset_midcount e3: got %0d want 5", Dout);
      end
      repeat (7) @(posedge clk);
      #1;
      n_checks++;
      if (Dout !== 32'd2) begin
         n_fail++;
         $display("FAIL coll_preset_reload e10: got %0d want 2", Dout);
      end
   endtask

   // Random PRESET/MODE/IM; expected values from the period timeline:
   // edge 1 loads, N' counting edges, then the interrupt edge (period N'+2).
   task automatic test_random();
      for (int s = 0; s < 10; s++) begin
         int unsigned n    = $urandom_range(0, 12);
         int unsigned mode = $urandom_range(0, 3);
         int unsigned im   = $urandom_range(0, 1);
         int unsigned np   = (n == 0) ? 1 : n;
         int unsigned p    = np + 2;
         bit          auto_rl = (mode == 1);
         do_reset();
         wr(2'd1, 32'(n));
         wr(2'd0, 32'((im << 3) | (mode << 1) | 1));
         for (int t = 1; t <= int'(2 * p + 3); t++) begin
            int unsigned exp_cnt;
            bit          exp_irq;
            bit          exp_en;
            int unsigned ph;
            if (!auto_rl && t >= int'(p)) begin
               exp_cnt = 0;
               exp_irq = (im != 0);
               exp_en  = (t == int'(p));
            end else begin
               ph      = (t - 1) % p;
               exp_en  = 1'b1;
               exp_irq = (ph == p - 1) && (im != 0);
               if (ph >= 1 && ph <= np) exp_cnt = n - (ph - 1);
               else                     exp_cnt = 0;
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (IRQ !== exp_irq) begin
               n_fail++;
               $display("FAIL rand_irq s%0d n%0d m%0d e%0d: got %b want %b", s, n, mode, t, IRQ, exp_irq);
            end
            Addr = 2'd2;
            #1;
            n_checks++;
            if (Dout !== 32'(exp_cnt)) begin
               n_fail++;
               $display("FAIL rand_count s%0d n%0d m%0d e%0d: got %0d want %0d", s, n, mode, t, Dout, exp_cnt);
            end
            Addr = 2'd0;
            #1;
            n_checks++;
            if (Dout !== 32'((im << 3) | (mode << 1) | int'(exp_en))) begin
               n_fail++;
               $display("FAIL rand_ctrl s%0d e%0d: got %h", s, t, Dout);
            end
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      Addr     = 2'd0;
      WE       = 1'b0;
      Din      = 32'd0;
      test_reset();
      test_oneshot();
      test_autoreload();
      test_masked();
      test_stop_restart();
      test_collisions();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
